icg_ctrl: RTL
=============

ICG_CTRL -- requirements
Module: icg_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independently gated clock channels (1..32).
REQ-002 SHALL have parameter IDLE_W, default 4, width of the idle-threshold counter.
REQ-003 SHALL have parameter WAKE_LAT, default 2, cycles from wake trigger to ack (1..15).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port busy  input  N_CH  per-channel activity; 1 = consumer needs clock.
REQ-007 SHALL have port req  input  N_CH  per-channel wake request.
REQ-008 SHALL have port force_on  input  N_CH  per-channel software override; 1 = never gate.
REQ-009 SHALL have port tst_en  input  1  scan/test enable; forces every clk_en high.
REQ-010 SHALL have port idle_thresh  input  IDLE_W  idle cycles before gating, shared by all channels.
REQ-011 SHALL have port clk_en  output  N_CH  enable driven to each channel's icg cell.
REQ-012 SHALL have port ack  output  N_CH  1 = channel clock running and stable.
REQ-013 SHALL have port gated  output  N_CH  1 = channel in OFF state.

Function
REQ-014 SHALL keep per channel a 4-state FSM {ON, COUNT, OFF, WAKE}, an IDLE_W-bit idle counter and a 4-bit wake counter.
REQ-015 SHALL define per channel wake = busy | req | force_on.
REQ-016 SHALL in ON: clk_en=1, ack=1; if !wake and idle_thresh!=0, go COUNT with idle counter=1 next cycle.
REQ-017 SHALL in ON with idle_thresh==0 stay ON (gating disabled).
REQ-018 SHALL in COUNT: clk_en=1, ack=1; if wake, go ON and clear counter; else if counter==idle_thresh, go OFF; else counter+1.
REQ-019 SHALL give wake priority over threshold match in the same cycle (COUNT -> ON).
REQ-020 SHALL in OFF: clk_en=0, ack=0, gated=1; if wake, go WAKE with wake counter=0.
REQ-021 SHALL in WAKE: clk_en=1, ack=0; wake counter+1 each cycle; at counter==WAKE_LAT-1 go ON.
REQ-022 SHALL ignore wake deassertion during WAKE (always completes to ON, then re-evaluates).
REQ-023 SHALL result in exactly WAKE_LAT cycles with clk_en=1, ack=0 between OFF exit and first ack=1.
REQ-024 SHALL assume idle_thresh may change any cycle; COUNT compares against current value; counter > new threshold -> OFF next cycle.
REQ-025 SHALL force clk_en[i]=1 for all i while tst_en=1, combinationally, without altering FSM, counters, ack or gated.
REQ-026 SHALL register ack and gated from state (no combinational path from inputs); clk_en = state-decode OR tst_en.
REQ-027 SHALL operate channels fully independently; no shared arbitration.
REQ-028 SHALL never exceed counter width: idle counter stops at idle_thresh, wake counter at WAKE_LAT-1.

Reset
REQ-029 SHALL on rst=1 at a clock edge put every channel in ON, clear all counters, giving clk_en=all ones, ack=all ones, gated=0 from the next cycle.
REQ-030 SHALL let rst override any state including mid-COUNT and mid-WAKE; no pending wake survives reset.
REQ-031 SHALL hold clk_en high throughout reset so downstream logic sees a running clock during its own reset.

Verification
REQ-032 SHALL cover: idle_thresh=3, ch0 busy drops at cycle 10 -> COUNT cycles 11-13, clk_en[0]=0/gated[0]=1 from cycle 14.
REQ-033 SHALL cover: ch0 OFF, req[0] pulse 1 cycle, WAKE_LAT=2 -> clk_en[0]=1 next cycle, ack[0]=0 two cycles, ack[0]=1 on third.
REQ-034 SHALL cover: busy reasserts on the cycle counter==idle_thresh -> channel returns ON, never gates.
REQ-035 SHALL cover: all channels OFF, tst_en=1 -> clk_en=all ones, gated stays all ones, ack all zeros; tst_en=0 -> clk_en all zeros.
REQ-036 SHALL cover: rst asserted while ch1 in WAKE and ch2 in COUNT -> both ON, ack=all ones next cycle; idle_thresh=0 -> no channel ever gates.

Source files
------------

// File: rtl/icg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icg_ctrl
// Purpose  : Per-channel clock-gating controller. Each channel runs its own
//            ON / COUNT / OFF / WAKE state machine. A channel gates its clock
//            after idle_thresh consecutive idle cycles. It ungates when
//            busy, req or force_on asserts, and raises ack exactly WAKE_LAT
//            cycles after clk_en returns high.
// Ports    : clk         - single clock, rising edge
//            rst         - synchronous active-high reset
//            busy[N_CH]  - per-channel activity (consumer needs clock)
//            req[N_CH]   - per-channel wake request
//            force_on    - per-channel override, never gate
//            tst_en      - scan/test enable, forces every clk_en high
//            idle_thresh - idle cycles before gating (0 disables gating)
//            clk_en      - enable to each channel's ICG cell
//            ack         - channel clock running and stable (registered)
//            gated       - channel in OFF state (registered)
// Revision : 1.0 - initial release
// ============================================================================
module icg_ctrl #(
    parameter int N_CH     = 4,
    parameter int IDLE_W   = 4,
    parameter int WAKE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   busy,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH-1:0]   force_on,
    input  logic              tst_en,
    input  logic [IDLE_W-1:0] idle_thresh,
    output logic [N_CH-1:0]   clk_en,
    output logic [N_CH-1:0]   ack,
    output logic [N_CH-1:0]   gated
);

    localparam logic [1:0] c_st_on    = 2'd0;
    localparam logic [1:0] c_st_count = 2'd1;
    localparam logic [1:0] c_st_off   = 2'd2;
    localparam logic [1:0] c_st_wake  = 2'd3;

    localparam logic [IDLE_W-1:0] c_idle_zero = '0;
    localparam logic [IDLE_W-1:0] c_idle_one  = IDLE_W'(1);
    localparam logic [3:0]        c_wake_last = 4'(WAKE_LAT - 1);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [1:0]        r_state;
        logic [IDLE_W-1:0] r_idle_cnt;
        logic [3:0]        r_wake_cnt;
        logic              r_ack;
        logic              r_gated;

        logic [1:0]        w_state_nxt;
        logic [IDLE_W-1:0] w_idle_nxt;
        logic [3:0]        w_wake_nxt;
        logic              w_wake;

        assign w_wake = busy[gi] | req[gi] | force_on[gi];

        always_comb begin
            w_state_nxt = r_state;
            w_idle_nxt  = r_idle_cnt;
            w_wake_nxt  = r_wake_cnt;
            case (r_state)
                c_st_on: begin
                    // A zero threshold disables gating for this channel.
                    if (!w_wake && (idle_thresh != c_idle_zero)) begin
                        w_state_nxt = c_st_count;
                        w_idle_nxt  = c_idle_one;
                    end
                end
                c_st_count: begin
                    // Wake wins over a threshold match in the same cycle.
                    // The >= also catches a threshold lowered below the
                    // running count, which gates on the next cycle.
                    if (w_wake) begin
                        w_state_nxt = c_st_on;
                        w_idle_nxt  = c_idle_zero;
                    end else if (r_idle_cnt >= idle_thresh) begin
                        w_state_nxt = c_st_off;
                        w_idle_nxt  = c_idle_zero;
                    end else begin
                        w_idle_nxt  = r_idle_cnt + c_idle_one;
                    end
                end
                c_st_off: begin
                    if (w_wake) begin
                        w_state_nxt = c_st_wake;
                        w_wake_nxt  = 4'd0;
                    end
                end
                default: begin
                    // WAKE always runs to completion regardless of wake.
                    if (r_wake_cnt >= c_wake_last) begin
                        w_state_nxt = c_st_on;
                        w_wake_nxt  = 4'd0;
                    end else begin
                        w_wake_nxt  = r_wake_cnt + 4'd1;
                    end
                end
            endcase
        end

        // ack/gated are registered from the next-state value so that they
        // line up with r_state while having no combinational input path.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state    <= c_st_on;
                r_idle_cnt <= c_idle_zero;
                r_wake_cnt <= 4'd0;
                r_ack      <= 1'b1;
                r_gated    <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_idle_cnt <= w_idle_nxt;
                r_wake_cnt <= w_wake_nxt;
                r_ack      <= (w_state_nxt == c_st_on) || (w_state_nxt == c_st_count);
                r_gated    <= (w_state_nxt == c_st_off);
            end
        end

        // rst is ORed in so downstream logic sees a running clock for the
        // whole reset, including the first cycle before the state is known.
        assign clk_en[gi] = (r_state != c_st_off) | tst_en | rst;
        assign ack[gi]    = r_ack;
        assign gated[gi]  = r_gated;
    end : g_ch

endmodule : icg_ctrl
`default_nettype wire
